smc_access_seq_lite30: RTL and testbench
========================================

SMC_ACCESS_SEQ_LITE30 -- requirements
Module: smc_access_seq_lite30

Interface
REQ-001 The block SHALL use one clock, hclk30, and a synchronous active-high reset, sys_reset30; all state SHALL update on the rising edge of hclk30 only.
REQ-002 Parameters SHALL be, one per line:
- RD_WS, 1, read wait states, 0..15.
- WR_WS, 1, write wait states, 0..15.
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
- hclk30  in  1  system clock.
- sys_reset30  in  1  synchronous reset, active high.
- new_access30  in  1  valid AHB access; address phase.
- n_read30  in  1  0=read, 1=write; address phase.
- xfer_size30  in  2  0=byte, 1=half, 2=word; address phase.
- addr  in  32  access address; address phase; aligned to size.
- write_data30  in  32  write data; data phase, the cycle after new_access30.
- smc_data_in30  in  8  external memory read data.
- smc_idle30  out  1  sequencer idle.
- smc_done30  out  1  last cycle of the current external beat.
- mac_done30  out  1  current beat is the final beat of the access.
- read_data30  out  32  assembled read data.
- smc_addr30  out  32  external byte address.
- smc_data_out30  out  8  external write data.
- smc_n_cs30  out  1  external chip select, active low.
- smc_n_oe30  out  1  external output enable, active low.
- smc_n_we30  out  1  external write enable, active low.

Function
REQ-010 The external bus SHALL be 8 bits wide; beats per access SHALL be 1, 2 or 4 for byte, half or word. xfer_size30=3 SHALL be treated as word.
REQ-011 The FSM SHALL have states IDLE, SETUP, STROBE and HOLD.
REQ-012 IDLE -> SETUP SHALL occur when new_access30=1; on that edge addr, xfer_size30 and n_read30 SHALL be latched, and the beat counter SHALL clear to 0.
REQ-013 write_data30 SHALL be latched on the edge leaving SETUP of beat 0 (the data phase).
REQ-014 SETUP SHALL last 1 cycle, then go to STROBE.
REQ-015 STROBE SHALL last WS+1 cycles, where WS=RD_WS for reads and WR_WS for writes, using a 4-bit down-counter; it then goes to HOLD.
REQ-016 From HOLD:
- If the beat is not the final beat: go to SETUP and increment the beat counter.
- If it is the final beat and new_access30=1: go to SETUP with a new latch (back-to-back).
- Otherwise: go to IDLE.
REQ-017 new_access30 SHALL be ignored in SETUP, in STROBE, and in HOLD of non-final beats.
REQ-018 smc_addr30 SHALL equal latched addr + beat (32-bit add, wraps modulo 2^32) in SETUP, STROBE and HOLD; it SHALL hold its last value in IDLE.
REQ-019 Byte lane: lane = (addr[1:0] + beat) mod 4.
- Write: smc_data_out30 = latched write_data30[8*lane+7 : 8*lane].
- Read: smc_data_in30 SHALL be sampled on the last STROBE edge into read_data30[8*lane+7 : 8*lane]; all other lanes SHALL be unchanged.
REQ-020 Strobes:
- smc_n_cs30 SHALL be 0 in SETUP, STROBE and HOLD.
- smc_n_oe30 SHALL be 0 in STROBE for reads only.
- smc_n_we30 SHALL be 0 in STROBE for writes only.
- All strobes SHALL be registered outputs and glitch-free.
REQ-021 smc_done30 SHALL be 1 exactly in HOLD.
REQ-022 mac_done30 SHALL be 1 in SETUP, STROBE and HOLD of the final beat only; smc_done30 & mac_done30 therefore pulses for exactly 1 cycle per access.
REQ-023 smc_idle30 SHALL be 1 in IDLE only.
REQ-024 Latency per access SHALL be beats*(WS+3) cycles from the new_access30 edge to the end of the final HOLD cycle.
REQ-025 read_data30 SHALL be valid during the final HOLD cycle and SHALL hold until the next read sample.

Reset
REQ-030 On sys_reset30=1 at a clock edge the FSM SHALL enter IDLE, including mid-access, and the in-progress access SHALL be abandoned.
REQ-031 After that reset edge:
- smc_n_cs30, smc_n_oe30, smc_n_we30 SHALL be 1.
- smc_done30 and mac_done30 SHALL be 0.
- smc_idle30 SHALL be 1.
- read_data30, smc_addr30 and smc_data_out30 SHALL be 0.
- The beat and wait counters SHALL be 0.
REQ-032 Reset SHALL take priority over new_access30 on the same edge.

Verification
REQ-040 Byte read, RD_WS=1, addr=0x103, smc_data_in30=0xA5 -> smc_n_oe30 low 2 cycles; smc_done30 & mac_done30 at cycle 4; read_data30[31:24]=0xA5.
REQ-041 Word write, WR_WS=0, addr=0x200, write_data30=0x11223344 -> smc_addr30 0x200..0x203 carry bytes 44,33,22,11; 4 smc_n_we30 pulses of 1 cycle each; 12 cycles total; mac_done30 high only in beat 3.
REQ-042 Half read, RD_WS=2, addr=0x12, bytes 0x5A then 0xC3 -> read_data30[31:16]=0xC35A; smc_done30 high twice, the second time together with mac_done30.
REQ-043 Back-to-back: a second new_access30 during the final HOLD -> next cycle is SETUP; smc_idle30 stays 0; no IDLE cycle.
REQ-044 sys_reset30 asserted during STROBE of beat 2 of a word write -> next cycle: all strobes 1, smc_idle30=1, no smc_done30.
REQ-045 Address wrap: word read at addr=0xFFFFFFFC -> smc_addr30 sequence 0xFFFFFFFC..0xFFFFFFFF; no wrap error; lanes 0..3 filled.

Source files
------------

// File: rtl/smc_access_seq_lite30_if.sv
// smc_access_seq_lite30 bus bundle.
// AHB-side request/data plus the 8-bit external memory pins.
interface smc_access_seq_lite30_if;
  logic        new_access30;
  logic        n_read30;
  logic [1:0]  xfer_size30;
  logic [31:0] addr;
  logic [31:0] write_data30;
  logic [7:0]  smc_data_in30;
  logic        smc_idle30;
  logic        smc_done30;
  logic        mac_done30;
  logic [31:0] read_data30;
  logic [31:0] smc_addr30;
  logic [7:0]  smc_data_out30;
  logic        smc_n_cs30;
  logic        smc_n_oe30;
  logic        smc_n_we30;

  modport slave (
    input  new_access30, n_read30, xfer_size30,
    input  addr, write_data30, smc_data_in30,
    output smc_idle30, smc_done30, mac_done30,
    output read_data30, smc_addr30, smc_data_out30,
    output smc_n_cs30, smc_n_oe30, smc_n_we30
  );

  modport master (
    output new_access30, n_read30, xfer_size30,
    output addr, write_data30, smc_data_in30,
    input  smc_idle30, smc_done30, mac_done30,
    input  read_data30, smc_addr30, smc_data_out30,
    input  smc_n_cs30, smc_n_oe30, smc_n_we30
  );
endinterface

// File: rtl/smc_access_seq_lite30.sv
// smc_access_seq_lite30: splits byte/half/word accesses into
// 8-bit external beats (SETUP, STROBE x WS+1, HOLD).
module smc_access_seq_lite30 #(
  parameter int RD_WS = 1,
  parameter int WR_WS = 1
) (
  input  logic hclk30,
  input  logic sys_reset30,
  smc_access_seq_lite30_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE, HOLD
  } state_t;

  state_t      state, nstate;
  logic [1:0]  beat, nbeat;
  logic [3:0]  wcnt, nwcnt;
  logic [31:0] lat_addr, naddr;
  logic [1:0]  lat_size, nsize;
  logic        lat_rd, nrd;
  logic [31:0] wdata, nwdata;
  logic        load;
  logic        last_beat;
  logic [1:0]  nlast;
  logic [1:0]  nlane, rlane;
  logic [7:0]  ndout;
  logic        sample;

  logic        idle_q, done_q, mac_q;
  logic        n_cs_q, n_oe_q, n_we_q;
  logic [31:0] rdata_q, saddr_q;
  logic [7:0]  dout_q;

  // index of the final beat: byte 0, half 1, word (and 3) 3
  function automatic logic [1:0] last_of(
    input logic [1:0] s
  );
    unique case (s)
      2'd0:    last_of = 2'd0;
      2'd1:    last_of = 2'd1;
      default: last_of = 2'd3;
    endcase
  endfunction

  assign last_beat = (beat == last_of(lat_size));

  always_comb begin
    load   = 1'b0;
    nstate = state;
    nbeat  = beat;
    nwcnt  = wcnt;
    unique case (state)
      IDLE: begin
        if (bus.new_access30) begin
          load   = 1'b1;
          nstate = SETUP;
          nbeat  = 2'd0;
        end
      end
      SETUP: begin
        nstate = STROBE;
        nwcnt  = lat_rd ? 4'(RD_WS) : 4'(WR_WS);
      end
      STROBE: begin
        if (wcnt == 4'd0) nstate = HOLD;
        else              nwcnt  = wcnt - 4'd1;
      end
      HOLD: begin
        if (!last_beat) begin
          nstate = SETUP;
          nbeat  = beat + 2'd1;
        end else if (bus.new_access30) begin
          load   = 1'b1;
          nstate = SETUP;
          nbeat  = 2'd0;
        end else begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    naddr  = load ? bus.addr : lat_addr;
    nsize  = load ? bus.xfer_size30 : lat_size;
    nrd    = load ? !bus.n_read30 : lat_rd;
    // write data arrives in the data phase, one cycle late
    nwdata = (state == SETUP && beat == 2'd0)
           ? bus.write_data30 : wdata;
    nlast  = last_of(nsize);
    nlane  = naddr[1:0] + nbeat;
    rlane  = lat_addr[1:0] + beat;
    ndout  = nwdata[{nlane, 3'b000} +: 8];
    sample = (state == STROBE) && (wcnt == 4'd0)
           && lat_rd;
  end

  always_ff @(posedge hclk30) begin
    if (sys_reset30) begin
      state    <= IDLE;
      beat     <= 2'd0;
      wcnt     <= 4'd0;
      lat_addr <= 32'd0;
      lat_size <= 2'd0;
      lat_rd   <= 1'b0;
      wdata    <= 32'd0;
      idle_q   <= 1'b1;
      done_q   <= 1'b0;
      mac_q    <= 1'b0;
      n_cs_q   <= 1'b1;
      n_oe_q   <= 1'b1;
      n_we_q   <= 1'b1;
      rdata_q  <= 32'd0;
      saddr_q  <= 32'd0;
      dout_q   <= 8'd0;
    end else begin
      state    <= nstate;
      beat     <= nbeat;
      wcnt     <= nwcnt;
      lat_addr <= naddr;
      lat_size <= nsize;
      lat_rd   <= nrd;
      wdata    <= nwdata;
      idle_q   <= (nstate == IDLE);
      done_q   <= (nstate == HOLD);
      mac_q    <= (nstate != IDLE)
               && (nbeat == nlast);
      n_cs_q   <= (nstate == IDLE);
      n_oe_q   <= !((nstate == STROBE) && nrd);
      n_we_q   <= !((nstate == STROBE) && !nrd);
      if (nstate != IDLE)
        saddr_q <= naddr + 32'(nbeat);
      if (nstate != IDLE && !nrd)
        dout_q <= ndout;
      if (sample)
        rdata_q[{rlane, 3'b000} +: 8] <= bus.smc_data_in30;
    end
  end

  assign bus.smc_idle30     = idle_q;
  assign bus.smc_done30     = done_q;
  assign bus.mac_done30     = mac_q;
  assign bus.smc_n_cs30     = n_cs_q;
  assign bus.smc_n_oe30     = n_oe_q;
  assign bus.smc_n_we30     = n_we_q;
  assign bus.read_data30    = rdata_q;
  assign bus.smc_addr30     = saddr_q;
  assign bus.smc_data_out30 = dout_q;

endmodule

// File: tb/tb_smc_access_seq_lite30.sv
// Directed bench for smc_access_seq_lite30.
// dut_a: RD_WS=1/WR_WS=0, dut_b: RD_WS=2/WR_WS=2 (shared inputs).
module tb_smc_access_seq_lite30;

  logic hclk30 = 1'b0;
  logic sys_reset30;
  always #5 hclk30 = ~hclk30;

  smc_access_seq_lite30_if bus_a ();
  smc_access_seq_lite30_if bus_b ();

  assign bus_b.new_access30  = bus_a.new_access30;
  assign bus_b.n_read30      = bus_a.n_read30;
  assign bus_b.xfer_size30   = bus_a.xfer_size30;
  assign bus_b.addr          = bus_a.addr;
  assign bus_b.write_data30  = bus_a.write_data30;
  assign bus_b.smc_data_in30 = bus_a.smc_data_in30;

  smc_access_seq_lite30 #(.RD_WS(1), .WR_WS(0)) dut_a (
    .hclk30      (hclk30),
    .sys_reset30 (sys_reset30),
    .bus         (bus_a.slave)
  );

  smc_access_seq_lite30 #(.RD_WS(2), .WR_WS(2)) dut_b (
    .hclk30      (hclk30),
    .sys_reset30 (sys_reset30),
    .bus         (bus_b.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge hclk30);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start(input logic rd,
                       input logic [1:0] sz,
                       input logic [31:0] a);
    bus_a.new_access30 = 1'b1;
    bus_a.n_read30     = !rd;
    bus_a.xfer_size30  = sz;
    bus_a.addr         = a;
  endtask

  int          cnt, cnt2, first, last;
  logic        prev_we;
  logic [31:0] wa [8];
  logic [7:0]  wd [8];
  int          wi;

  initial begin
    sys_reset30         = 1'b1;
    bus_a.new_access30  = 1'b0;
    bus_a.n_read30      = 1'b0;
    bus_a.xfer_size30   = 2'd0;
    bus_a.addr          = 32'd0;
    bus_a.write_data30  = 32'd0;
    bus_a.smc_data_in30 = 8'd0;
    wait_n(2);

    // reset state
    chk("rst_idle", 32'(bus_a.smc_idle30), 32'd1);
    chk("rst_cs",   32'(bus_a.smc_n_cs30), 32'd1);
    chk("rst_oe",   32'(bus_a.smc_n_oe30), 32'd1);
    chk("rst_we",   32'(bus_a.smc_n_we30), 32'd1);
    chk("rst_done", 32'(bus_a.smc_done30), 32'd0);
    chk("rst_mac",  32'(bus_a.mac_done30), 32'd0);
    chk("rst_rd",   bus_a.read_data30, 32'd0);
    chk("rst_addr", bus_a.smc_addr30, 32'd0);
    chk("rst_dout", 32'(bus_a.smc_data_out30), 32'd0);
    sys_reset30 = 1'b0;
    wait_n(2);

    // byte read, RD_WS=1, addr 0x103
    start(1'b1, 2'd0, 32'h103);
    bus_a.smc_data_in30 = 8'hA5;
    cnt = 0; first = 0; cnt2 = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus_a.new_access30 = 1'b0;
      if (k == 1)
        chk("t1_addr", bus_a.smc_addr30, 32'h103);
      if (k <= 4) begin
        if (!bus_a.smc_n_oe30) cnt++;
        if (bus_a.smc_done30 && bus_a.mac_done30) begin
          cnt2++;
          first = k;
        end
      end
      if (k == 4)
        chk("t1_rdata", 32'(bus_a.read_data30[31:24]),
            32'hA5);
      if (k == 5)
        chk("t1_idle", 32'(bus_a.smc_idle30), 32'd1);
    end
    chk("t1_oe_cycles", cnt, 2);
    chk("t1_dm_count", cnt2, 1);
    chk("t1_dm_cycle", first, 4);
    wait_n(10);

    // word write, WR_WS=0, addr 0x200
    start(1'b0, 2'd2, 32'h200);
    cnt = 0; cnt2 = 0; first = 0; last = 0;
    wi = 0; prev_we = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 1) begin
        bus_a.new_access30 = 1'b0;
        bus_a.write_data30 = 32'h11223344;
      end
      if (k == 2) bus_a.write_data30 = 32'hDEADBEEF;
      if (k <= 12) begin
        if (!bus_a.smc_n_we30 && wi < 8) begin
          wa[wi] = bus_a.smc_addr30;
          wd[wi] = bus_a.smc_data_out30;
          wi++;
        end
        if (!bus_a.smc_n_we30 && prev_we) cnt++;
        prev_we = bus_a.smc_n_we30;
        if (bus_a.mac_done30) begin
          cnt2++;
          if (first == 0) first = k;
        end
        if (bus_a.smc_done30) last = k;
      end
      if (k == 13)
        chk("t2_idle", 32'(bus_a.smc_idle30), 32'd1);
    end
    chk("t2_we_cycles", wi, 4);
    chk("t2_we_pulses", cnt, 4);
    chk("t2_mac_cycles", cnt2, 3);
    chk("t2_mac_first", first, 10);
    chk("t2_last_done", last, 12);
    chk("t2_a0", wa[0], 32'h200);
    chk("t2_a3", wa[3], 32'h203);
    chk("t2_d0", 32'(wd[0]), 32'h44);
    chk("t2_d1", 32'(wd[1]), 32'h33);
    chk("t2_d2", 32'(wd[2]), 32'h22);
    chk("t2_d3", 32'(wd[3]), 32'h11);
    wait_n(25);

    // half read on dut_b, RD_WS=2, addr 0x12
    start(1'b1, 2'd1, 32'h12);
    bus_a.smc_data_in30 = 8'h5A;
    cnt = 0; cnt2 = 0; first = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      bus_a.new_access30 = 1'b0;
      if (k <= 10) begin
        if (!bus_b.smc_n_oe30) cnt++;
        if (bus_b.smc_done30) cnt2++;
        if (bus_b.smc_done30 && bus_b.mac_done30)
          first = k;
      end
      if (k == 10)
        chk("t3_rdata", 32'(bus_b.read_data30[31:16]),
            32'hC35A);
      if (k == 11)
        chk("t3_idle", 32'(bus_b.smc_idle30), 32'd1);
      if (k >= 5) bus_a.smc_data_in30 = 8'hC3;
    end
    chk("t3_oe_cycles", cnt, 6);
    chk("t3_done_count", cnt2, 2);
    chk("t3_dm_cycle", first, 10);
    wait_n(25);

    // back-to-back: byte read 0x40 then byte write 0x41
    start(1'b1, 2'd0, 32'h40);
    cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      bus_a.new_access30 = 1'b0;
      if (k <= 7 && bus_a.smc_idle30) cnt++;
      if (k == 2) start(1'b0, 2'd0, 32'h80);
      if (k == 3)
        chk("t4_ignore", bus_a.smc_addr30, 32'h40);
      if (k == 4) begin
        chk("t4_hold", 32'(bus_a.smc_done30), 32'd1);
        start(1'b0, 2'd0, 32'h41);
      end
      if (k == 5) begin
        chk("t4_b2b_addr", bus_a.smc_addr30, 32'h41);
        chk("t4_b2b_cs", 32'(bus_a.smc_n_cs30), 32'd0);
        chk("t4_b2b_done", 32'(bus_a.smc_done30), 32'd0);
        bus_a.write_data30 = 32'h0000BE00;
      end
      if (k == 6) begin
        chk("t4_we", 32'(bus_a.smc_n_we30), 32'd0);
        chk("t4_dout", 32'(bus_a.smc_data_out30),
            32'hBE);
      end
      if (k == 8)
        chk("t4_idle_end", 32'(bus_a.smc_idle30), 32'd1);
    end
    chk("t4_no_idle", cnt, 0);
    wait_n(25);

    // reset during STROBE of beat 2 of a word write
    start(1'b0, 2'd2, 32'h300);
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) begin
        bus_a.new_access30 = 1'b0;
        bus_a.write_data30 = 32'hA1B2C3D4;
      end
      if (k == 8) begin
        chk("t5_pre_we", 32'(bus_a.smc_n_we30), 32'd0);
        chk("t5_pre_dout", 32'(bus_a.smc_data_out30),
            32'hB2);
        sys_reset30 = 1'b1;
        bus_a.new_access30 = 1'b1;
      end
      if (k == 9) begin
        chk("t5_cs", 32'(bus_a.smc_n_cs30), 32'd1);
        chk("t5_oe", 32'(bus_a.smc_n_oe30), 32'd1);
        chk("t5_we", 32'(bus_a.smc_n_we30), 32'd1);
        chk("t5_idle", 32'(bus_a.smc_idle30), 32'd1);
        chk("t5_done", 32'(bus_a.smc_done30), 32'd0);
        chk("t5_mac", 32'(bus_a.mac_done30), 32'd0);
        chk("t5_addr", bus_a.smc_addr30, 32'd0);
      end
      if (k == 10) begin
        chk("t5_rst_prio", 32'(bus_a.smc_idle30), 32'd1);
        sys_reset30 = 1'b0;
        bus_a.new_access30 = 1'b0;
      end
      if (k == 11)
        chk("t5_stay_idle", 32'(bus_a.smc_n_cs30), 32'd1);
    end
    wait_n(5);

    // word read across the top of the address space
    start(1'b1, 2'd2, 32'hFFFFFFFC);
    bus_a.smc_data_in30 = 8'hD0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      bus_a.new_access30 = 1'b0;
      if (k <= 13 && (k % 4) == 1)
        chk("t6_addr", bus_a.smc_addr30,
            32'hFFFFFFFC + 32'((k - 1) / 4));
      if (k == 16) begin
        chk("t6_rdata", bus_a.read_data30,
            32'hD3D2D1D0);
        chk("t6_dm", 32'(bus_a.smc_done30
            && bus_a.mac_done30), 32'd1);
      end
      if (k == 17)
        chk("t6_idle", 32'(bus_a.smc_idle30), 32'd1);
      bus_a.smc_data_in30 = 8'hD0 + 8'(k / 4);
    end
    wait_n(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
